fb_read_arbiter: RTL
====================

Name: fb_read_arbiter

Overview:
- Shares the single SRAM frame-buffer AXI read port between two read masters: the display pixel stream ("disp") and a blitter/readback engine ("blt").
- The display is strictly favoured, with a bounded-streak fairness guard so blt is never starved.
- Responses are returned in order to the master that issued each read. An ID FIFO records the grant order, so the SRAM controller may pipeline up to MAX_OUTSTANDING reads.
- Sits between vga_fb_pixel_stream/blitter and the SRAM AXI controller, in the AXI clock domain.

Parameters:
- AXI_ADDR_WIDTH, 20, address width, all ports.
- AXI_DATA_WIDTH, 16, read data width.
- MAX_OUTSTANDING, 4, max accepted-but-unanswered reads; also the route FIFO depth.
- DISP_STREAK, 8, max consecutive disp grants while blt is waiting.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- disp_axi_araddr  in  AXI_ADDR_WIDTH  display read address.
- disp_axi_arvalid  in  1  display address valid.
- disp_axi_arready  out  1  display address accepted.
- disp_axi_rdata  out  AXI_DATA_WIDTH  display read data.
- disp_axi_rresp  out  2  display read response.
- disp_axi_rvalid  out  1  display data valid.
- disp_axi_rready  in  1  display data ready.
- blt_axi_araddr  in  AXI_ADDR_WIDTH  blitter read address.
- blt_axi_arvalid  in  1  blitter address valid.
- blt_axi_arready  out  1  blitter address accepted.
- blt_axi_rdata  out  AXI_DATA_WIDTH  blitter read data.
- blt_axi_rresp  out  2  blitter read response.
- blt_axi_rvalid  out  1  blitter data valid.
- blt_axi_rready  in  1  blitter data ready.
- sram_axi_araddr  out  AXI_ADDR_WIDTH  SRAM read address (registered).
- sram_axi_arvalid  out  1  SRAM address valid (registered).
- sram_axi_arready  in  1  SRAM address accepted.
- sram_axi_rdata  in  AXI_DATA_WIDTH  SRAM read data.
- sram_axi_rresp  in  2  SRAM read response.
- sram_axi_rvalid  in  1  SRAM data valid.
- sram_axi_rready  out  1  SRAM data ready.

Behaviour:
- Reset values:
  - sram_axi_arvalid=0, sram_axi_araddr=0.
  - Route FIFO empty, streak counter=0.
  - Outputs: disp/blt arready=0, disp/blt rvalid=0, sram_axi_rready=0.
  - A reset mid-operation discards all in-flight routing; the SRAM controller shares the same reset.
- Grant slot is open when both hold:
  - (!sram_axi_arvalid | sram_axi_arready), and
  - (route count < MAX_OUTSTANDING, or a pop occurs this cycle).
- Winner selection, only while the slot is open:
  - If streak==DISP_STREAK and blt_arvalid, the winner is blt.
  - Else if disp_arvalid, the winner is disp.
  - Else if blt_arvalid, the winner is blt.
  - Else there is no grant.
- On a grant:
  - The winner's arready is high combinationally that cycle (it may depend on arvalid). The loser's arready is 0.
  - Next cycle: sram_axi_araddr <= winner addr and sram_axi_arvalid <= 1. Address latency is exactly 1 cycle.
  - The winner ID (0=disp, 1=blt) is pushed into the route FIFO.
- sram_axi_arvalid:
  - Clears on acceptance when there is no new grant.
  - A new grant in the accept cycle keeps it high with the new address (back-to-back, one read per cycle).
- Streak counter, saturating at DISP_STREAK:
  - Increments on a disp grant while blt_arvalid=1.
  - Clears on a blt grant, or in any cycle with blt_arvalid=0.
- Response routing, with head = route FIFO head:
  - sram_axi_rdata and sram_axi_rresp are broadcast to both masters.
  - disp_axi_rvalid = sram_axi_rvalid & !empty & head==0; blt_axi_rvalid likewise for head==1.
  - sram_axi_rready = !empty & (head==0 ? disp_axi_rready : blt_axi_rready). It is 0 when the FIFO is empty.
  - Pop on sram_axi_rvalid & sram_axi_rready.
- Simultaneous push and pop: count unchanged. A full FIFO with a pop in the same cycle still allows a grant.
- Back-pressure: a master holding rready=0 stalls all later responses, enforcing in-order delivery. Grants continue until the FIFO is full.
- Address is held while arvalid=1 and arready=0; the arbiter does not drop requests.

Test Plan:
- Disp only, 8 back-to-back reads at addrs 0..7, sram_arready=1, sram_rvalid 2 cycles after each accept:
  - sram_axi_araddr is 0..7 on consecutive cycles.
  - disp receives 8 responses in order; blt_rvalid never asserts.
- Both arvalid held continuously, DISP_STREAK=8:
  - Grant pattern is 8 disp then 1 blt, repeating.
  - Streak clears after each blt grant.
- blt request alone, then disp arrives during the blt-granted cycle:
  - blt is granted first, disp on the next slot.
  - Responses are routed blt then disp.
- sram_axi_rvalid held low, 6 disp requests:
  - Exactly 4 are granted (MAX_OUTSTANDING).
  - arready stays 0 until the first pop, then one grant occurs in the same cycle as the pop.
- Interleaved disp/blt responses pending, blt_rready=0 while the head is blt:
  - sram_axi_rready=0 and disp_axi_rvalid=0 until blt_rready rises.
  - Data arrives intact at the correct masters.
- Reset asserted with 3 reads outstanding:
  - Next cycle: FIFO empty, sram_axi_arvalid=0, all rvalid=0.
  - A fresh disp request is granted normally.

Source files
------------

// File: rtl/fb_read_arbiter_if.sv
// fb_read_arbiter_if: one AXI read channel (AR + R) between a read master and a read slave
// master drives araddr/arvalid/rready and receives arready/rdata/rresp/rvalid; slave is the mirror
interface fb_read_arbiter_if #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16
);
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares the SRAM frame-buffer AXI read port between display (favoured) and blitter
// clk/reset: clock and synchronous active-high reset
// disp, blt: read masters (slave side of their channels); sram: read slave (master side)
// Requests are granted into a registered AR stage; a route FIFO of grant IDs steers in-order responses.
module fb_read_arbiter #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DISP_STREAK     = 8
) (
  input  logic                clk,
  input  logic                reset,
  fb_read_arbiter_if.slave    disp,
  fb_read_arbiter_if.slave    blt,
  fb_read_arbiter_if.master   sram
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(DISP_STREAK + 1);
  logic [MAX_OUTSTANDING-1:0] route_q, route_d;
  logic [PW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              streak_q, streak_d;
  logic [AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic                       arvalid_q, arvalid_d;
  logic                       live, head, rr, pop, slot, blt_turn, blt_win, disp_win, push;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction
  // A pop in the same cycle frees a FIFO entry, so a full FIFO can still take a grant.
  always_comb begin
    live      = !reset && cnt_q != '0;
    head      = route_q[rd_q];
    rr        = live && (head ? blt.rready : disp.rready);
    pop       = rr && sram.rvalid;
    slot      = !reset && (!arvalid_q || sram.arready) && (cnt_q < CW'(MAX_OUTSTANDING) || pop);
    blt_turn  = streak_q == SW'(DISP_STREAK) && blt.arvalid;
    blt_win   = slot && blt.arvalid && (blt_turn || !disp.arvalid);
    disp_win  = slot && disp.arvalid && !blt_turn;
    push      = disp_win || blt_win;
    araddr_d  = push ? (blt_win ? blt.araddr : disp.araddr) : araddr_q;
    arvalid_d = push || (arvalid_q && !sram.arready);
    streak_d  = (!blt.arvalid || blt_win) ? '0 :
                (disp_win && streak_q != SW'(DISP_STREAK)) ? streak_q + SW'(1) : streak_q;
    route_d   = route_q;
    if (push) route_d[wr_q] = blt_win;
    wr_d      = push ? nxt(wr_q) : wr_q;
    rd_d      = pop ? nxt(rd_q) : rd_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      route_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      streak_q  <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      route_q   <= route_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end
  assign disp.arready = disp_win;
  assign blt.arready  = blt_win;
  assign disp.rdata   = sram.rdata;
  assign disp.rresp   = sram.rresp;
  assign blt.rdata    = sram.rdata;
  assign blt.rresp    = sram.rresp;
  assign disp.rvalid  = live && sram.rvalid && !head;
  assign blt.rvalid   = live && sram.rvalid && head;
  assign sram.rready  = rr;
  assign sram.araddr  = araddr_q;
  assign sram.arvalid = arvalid_q;
endmodule
